line_mem_responder: RTL and testbench

- Memory-side responder for the cache's line interface: `memory_cmd_*` and `memory_rsp_*`, viewed from the slave end.
- Accepts one 256-bit line read or write command. Serializes it into 8 beats on a 32-bit single-port SRAM with 1-cycle read latency, and returns read lines as one 256-bit response beat.
- Sits between the cache and on-chip main memory.

---
 rtl/line_mem_responder_pkg.sv | 41 ++++
 rtl/line_mem_responder_pack.sv | 36 +++
 rtl/line_mem_responder.sv | 143 ++++++++++++++
 tb/tb_line_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// line_mem_responder_pkg
//   Shared constants, FSM state encoding and line/beat address helpers for the
//   line_mem_responder block (memory side of the cache line interface).
//   Widths match the cache's MEMORY_DW / ALL_ADDR_LEN parameters.
// ---------------------------------------------------------------------------
package line_mem_responder_pkg;

   localparam int unsigned ALL_ADDR_LEN = 24;               // byte address width
   localparam int unsigned MEMORY_DW    = 256;              // line width
   localparam int unsigned MEMORY_MW    = MEMORY_DW / 8;    // line byte enables
   localparam int unsigned SRAM_DW      = 32;               // SRAM word width
   localparam int unsigned SRAM_MW      = SRAM_DW / 8;      // SRAM byte enables
   localparam int unsigned SRAM_BMW     = 2;                // log2(SRAM_MW)
   localparam int unsigned BEAT_LEN     = 3;                // log2(beats per line)
   localparam int unsigned SRAM_AW      = ALL_ADDR_LEN - SRAM_BMW;
   localparam int unsigned LINE_AW      = ALL_ADDR_LEN - BEAT_LEN - SRAM_BMW;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   typedef logic [LINE_AW-1:0]  line_addr_t;
   typedef logic [BEAT_LEN-1:0] beat_t;

   // Line number of a byte address; the in-line offset bits are dropped.
   function automatic line_addr_t line_of(input logic [ALL_ADDR_LEN-1:0] addr);
      return addr[ALL_ADDR_LEN-1:BEAT_LEN+SRAM_BMW];
   endfunction

   // SRAM word address of beat b within line l.
   function automatic logic [SRAM_AW-1:0] word_addr(input line_addr_t l, input beat_t b);
      return {l, b};
   endfunction

endpackage

// File: rtl/line_mem_responder_pack.sv
// ---------------------------------------------------------------------------
// line_beat_pack
//   Assembles 32-bit SRAM read words into a 256-bit line register, one slot
//   per beat index. The register holds its contents until the next load or
//   reset, so it doubles as the stable read-response data.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_load    - write i_word into slot i_idx this cycle
//   i_idx     - beat slot index (0 = lowest address, low bits of the line)
//   i_word    - SRAM read word
//   o_line    - assembled line
// ---------------------------------------------------------------------------
module line_beat_pack
   import line_mem_responder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic [BEAT_LEN-1:0]  i_idx,
   input  logic [SRAM_DW-1:0]   i_word,
   output logic [MEMORY_DW-1:0] o_line
);

   logic [MEMORY_DW-1:0] r_line;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line <= '0;
      end else if (i_load) begin
         r_line[int'(i_idx)*SRAM_DW +: SRAM_DW] <= i_word;
      end
   end

   assign o_line = r_line;

endmodule

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
//   Slave end of the cache line interface. Accepts one 256-bit line read or
//   write command at a time and serializes it into 8 beats on a 32-bit
//   single-port SRAM (1-cycle read latency). Reads return the whole line as a
//   single response beat; writes complete when cmd_ready re-asserts.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (ready only while idle)
//   cmd_read              - 1 = line read, 0 = line write
//   cmd_addr              - byte address, line aligned (offset bits ignored)
//   cmd_wdata/cmd_wmask   - write line and byte enables
//   rsp_valid/rsp_ready   - read response handshake
//   rsp_rdata             - read line, lowest address in low bits
//   sram_en/we/addr/wdata - SRAM request port (we = 0 means read)
//   sram_rdata            - SRAM read data, one cycle after a read
// ---------------------------------------------------------------------------
module line_mem_responder
   import line_mem_responder_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_read,
   input  logic [ALL_ADDR_LEN-1:0] cmd_addr,
   input  logic [MEMORY_DW-1:0]    cmd_wdata,
   input  logic [MEMORY_MW-1:0]    cmd_wmask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [MEMORY_DW-1:0]    rsp_rdata,
   output logic                    sram_en,
   output logic [SRAM_MW-1:0]      sram_we,
   output logic [SRAM_AW-1:0]      sram_addr,
   output logic [SRAM_DW-1:0]      sram_wdata,
   input  logic [SRAM_DW-1:0]      sram_rdata
);

   state_t               r_state;
   beat_t                r_beat;     // beat currently presented on the SRAM port
   line_addr_t           r_line;
   logic                 r_read;
   logic [MEMORY_DW-1:0] r_wdata;
   logic [MEMORY_MW-1:0] r_wmask;

   beat_t                w_next_beat;
   logic                 w_cap_en;
   beat_t                w_cap_idx;

   assign w_next_beat = r_beat + beat_t'(1);

   // Read data trails the issued beat by one cycle, so the slot written is
   // always r_beat-1. In DRAIN the counter has wrapped to 0, giving slot 7.
   assign w_cap_en  = ((r_state == ST_READ) && (r_beat != '0)) || (r_state == ST_DRAIN);
   assign w_cap_idx = r_beat - beat_t'(1);

   line_beat_pack u_pack (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_cap_en),
      .i_idx  (w_cap_idx),
      .i_word (sram_rdata),
      .o_line (rsp_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_beat     <= '0;
         r_line     <= '0;
         r_read     <= 1'b0;
         r_wdata    <= '0;
         r_wmask    <= '0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_state   <= ST_IDLE;
               cmd_ready <= 1'b1;
            end

            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  // Beat 0 is presented straight from the command inputs so
                  // the first SRAM access lands in the cycle after accept.
                  r_line     <= line_of(cmd_addr);
                  r_read     <= cmd_read;
                  r_wdata    <= cmd_wdata;
                  r_wmask    <= cmd_wmask;
                  r_beat     <= '0;
                  cmd_ready  <= 1'b0;
                  sram_en    <= 1'b1;
                  sram_addr  <= word_addr(line_of(cmd_addr), '0);
                  sram_wdata <= cmd_wdata[SRAM_DW-1:0];
                  sram_we    <= cmd_read ? '0 : cmd_wmask[SRAM_MW-1:0];
                  r_state    <= cmd_read ? ST_READ : ST_WRITE;
               end
            end

            ST_WRITE, ST_READ: begin
               r_beat <= w_next_beat;
               if (r_beat == '1) begin
                  sram_en <= 1'b0;
                  sram_we <= '0;
                  if (r_state == ST_WRITE) begin
                     r_state   <= ST_IDLE;
                     cmd_ready <= 1'b1;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end else begin
                  sram_addr  <= word_addr(r_line, w_next_beat);
                  sram_wdata <= r_wdata[int'(w_next_beat)*SRAM_DW +: SRAM_DW];
                  sram_we    <= r_read ? '0 : r_wmask[int'(w_next_beat)*SRAM_MW +: SRAM_MW];
               end
            end

            ST_DRAIN: begin
               r_state   <= ST_RESP;
               rsp_valid <= 1'b1;
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;
   import line_mem_responder_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    cmd_valid = 1'b0;
   logic                    cmd_ready;
   logic                    cmd_read = 1'b0;
   logic [ALL_ADDR_LEN-1:0] cmd_addr = '0;
   logic [MEMORY_DW-1:0]    cmd_wdata = '0;
   logic [MEMORY_MW-1:0]    cmd_wmask = '0;
   logic                    rsp_valid;
   logic                    rsp_ready = 1'b0;
   logic [MEMORY_DW-1:0]    rsp_rdata;
   logic                    sram_en;
   logic [SRAM_MW-1:0]      sram_we;
   logic [SRAM_AW-1:0]      sram_addr;
   logic [SRAM_DW-1:0]      sram_wdata;
   logic [SRAM_DW-1:0]      sram_rdata = '0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   localparam logic [255:0] W1 = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
   localparam logic [255:0] WP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF;
   localparam logic [255:0] RP = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_DEADBEEF;
   localparam logic [255:0] WT = 256'hA7A7A7A7_A6A6A6A6_A5A5A5A5_A4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;

   line_mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_read   (cmd_read),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wmask  (cmd_wmask),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM, read-first, 1-cycle read latency.
   bit [31:0] mem [bit [21:0]];
   bit [31:0] mem_tmp;
   always @(posedge clk) begin
      if (sram_en) begin
         mem_tmp = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
         sram_rdata <= mem_tmp;
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem_tmp[b*8 +: 8] = sram_wdata[b*8 +: 8];
         if (sram_we != '0) mem[sram_addr] = mem_tmp;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts and ends on a negedge with the DUT idle.
   task automatic do_write(input logic [23:0] addr, input logic [255:0] wd,
                           input logic [31:0] wm, input logic [21:0] base);
      check("wr_idle_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_read = 0; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = wm;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("wr_en%0d", k), sram_en, 1);
         check($sformatf("wr_addr%0d", k), sram_addr, base + 22'(k));
         check($sformatf("wr_we%0d", k), sram_we, wm[k*4 +: 4]);
         check($sformatf("wr_data%0d", k), sram_wdata, wd[k*32 +: 32]);
         check($sformatf("wr_busy%0d", k), cmd_ready, 0);
         @(negedge clk);
      end
      check("wr_done_ready", cmd_ready, 1);
      check("wr_done_en", sram_en, 0);
   endtask

   task automatic do_read(input logic [23:0] addr, input logic [21:0] base,
                          input logic [255:0] exp, input int hold, input logic early);
      check("rd_idle_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_read = 1; cmd_addr = addr; rsp_ready = early;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rd_en%0d", k), sram_en, 1);
         check($sformatf("rd_we%0d", k), sram_we, 0);
         check($sformatf("rd_addr%0d", k), sram_addr, base + 22'(k));
         check($sformatf("rd_nvalid%0d", k), rsp_valid, 0);
         @(negedge clk);
      end
      check("rd_drain_en", sram_en, 0);
      check("rd_drain_valid", rsp_valid, 0);
      @(negedge clk);
      check("rd_valid_t10", rsp_valid, 1);
      check("rd_data", rsp_rdata, exp);
      check("rd_resp_ready", cmd_ready, 0);
      if (!early) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rd_hold_valid", rsp_valid, 1);
            check("rd_hold_data", rsp_rdata, exp);
            check("rd_hold_cready", cmd_ready, 0);
            check("rd_hold_en", sram_en, 0);
         end
         rsp_ready = 1;
      end
      @(negedge clk);
      check("rd_post_valid", rsp_valid, 0);
      check("rd_post_ready", cmd_ready, 1);
      check("rd_post_data", rsp_rdata, exp);
      rsp_ready = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int          n_acc;
      int          acc [8];
      logic        pend;
      logic        seen;
      logic [39:0] times;

      #2 rst = 1;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_sram_en", sram_en, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_sram_addr", sram_addr, 0);
      check("rst_sram_wdata", sram_wdata, 0);
      rst = 0;
      @(negedge clk);
      check("init_to_idle", cmd_ready, 1);

      // Full line write then readback with a delayed rsp_ready.
      do_write(24'h000120, W1, 32'hFFFFFFFF, 22'h48);
      do_read(24'h000120, 22'h48, W1, 5, 1'b0);

      // Partial write at an unaligned address; only word 0 changes.
      do_write(24'h00013F, WP, 32'h0000000F, 22'h48);
      do_read(24'h00013F, 22'h48, RP, 0, 1'b1);

      // cmd_valid held high with alternating write/read commands.
      cmd_valid = 1; cmd_read = 0; cmd_addr = 24'h000120; cmd_wdata = W1;
      cmd_wmask = '1; rsp_ready = 1; pend = 0; n_acc = 0;
      for (int c = 0; c <= 40; c++) begin
         if (pend) begin cmd_read = ~cmd_read; pend = 0; end
         if (cmd_ready) begin
            if (n_acc < 8) acc[n_acc] = c;
            n_acc++;
            pend = 1;
         end
         @(negedge clk);
      end
      cmd_valid = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = cmd_ready;
      end
      rsp_ready = 0;
      check("cont_finish", seen, 1);
      check("cont_count", n_acc, 5);
      times = {acc[0][7:0], acc[1][7:0], acc[2][7:0], acc[3][7:0], acc[4][7:0]};
      check("cont_times", times, {8'd0, 8'd9, 8'd20, 8'd29, 8'd40});
      check("cont_rdata", rsp_rdata, W1);

      // Reset in the middle of a read.
      cmd_valid = 1; cmd_read = 1; cmd_addr = 24'h000120;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      #1;
      check("mrst_en", sram_en, 0);
      check("mrst_cready", cmd_ready, 0);
      check("mrst_valid", rsp_valid, 0);
      check("mrst_rdata", rsp_rdata, 0);
      repeat (2) @(negedge clk);
      check("mrst_hold_cready", cmd_ready, 0);
      rst = 0;
      @(negedge clk);
      check("mrst_release_ready", cmd_ready, 1);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid || sram_en) seen = 1;
      end
      check("mrst_no_response", seen, 0);

      // Top-of-memory line.
      do_write(24'hFFFFE0, WT, 32'hFFFFFFFF, 22'h3FFFF8);
      do_read(24'hFFFFE0, 22'h3FFFF8, WT, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
